leiwand_wb_master: RTL and testbench

//  Parametrised Wishbone B4 master bridging the leiwand_rv32 core's load/store/fetch path to the system bus.
//  - Core side: valid/ready request channel plus a one-cycle response pulse.
//  - Bus side: classic or pipelined Wishbone, selected by parameter.
//  - Adds byte selects, bus-error reporting and a cycle timeout. One transaction outstanding at a time.

---
 rtl/leiwand_wb_master_pkg.sv | 18 +
 rtl/leiwand_timeout_ctr.sv | 44 ++++
 rtl/leiwand_wb_master.sv | 159 +++++++++++++++
 tb/tb_leiwand_wb_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leiwand_wb_master_pkg.sv
// Shared definitions for the leiwand Wishbone master and its timeout counter:
// default bus width, FSM state encodings and a counter-width helper.
package leiwand_wb_master_pkg;

  localparam int MEM_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } wbm_state_e;

  // Smallest width that can hold the value max_val (at least one bit).
  function automatic int ctr_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/leiwand_timeout_ctr.sv
// Saturating cycle counter with an expiry flag. o_expired rises in the
// MAX-th enabled cycle after a clear, so the owner can abort on that edge.
// MAX = 0 disables expiry entirely.
module leiwand_timeout_ctr
  import leiwand_wb_master_pkg::*;
#(
  parameter int MAX = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int             CW    = ctr_width(MAX);
  localparam logic [CW-1:0]  LIMIT = CW'(MAX);
  localparam logic [CW-1:0]  LAST  = CW'((MAX > 0) ? (MAX - 1) : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count enabled cycles and stick at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds completed enabled cycles; the current one is the MAX-th when cnt_q == MAX-1.
  assign o_expired = (MAX != 0) && i_en && (cnt_q == LAST);

endmodule

// File: rtl/leiwand_wb_master.sv
// Wishbone B4 master for the leiwand_rv32 load/store/fetch path.
// One transaction in flight; classic or pipelined bus protocol chosen by
// PIPELINED; bus errors and timeouts are reported through o_rsp_err.
module leiwand_wb_master
  import leiwand_wb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = MEM_WIDTH,
  parameter int DATA_WIDTH     = MEM_WIDTH,
  parameter int PIPELINED      = 1,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [SEL_WIDTH-1:0]  i_req_sel,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_adr,
  output logic [DATA_WIDTH-1:0] o_wb_dat,
  output logic [SEL_WIDTH-1:0]  o_wb_sel,
  input  logic [DATA_WIDTH-1:0] i_wb_dat,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_err,
  input  logic                  i_wb_stall
);

  wbm_state_e state_q, state_d;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic accept;
  logic active;
  logic timed_out;
  logic done;
  logic done_err;

  assign accept   = i_req_valid && (state_q == ST_IDLE);
  assign active   = (state_q != ST_IDLE);
  // Acks/errs outside a cycle are ignored because done requires an active cycle.
  assign done     = active && (i_wb_ack || i_wb_err || timed_out);
  // Bus error beats ack; a timeout only counts when the slave stayed silent.
  assign done_err = i_wb_err || (!i_wb_ack && timed_out);

  leiwand_timeout_ctr #(
    .MAX (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (accept),
    .i_en      (active),
    .o_expired (timed_out)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: pipelined mode leaves REQ once the strobe is taken; classic holds it to the end.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ: begin
        if (done) begin
          state_d = ST_IDLE;
        end else if ((PIPELINED != 0) && !i_wb_stall) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: if (done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; bus fields come straight from their registers.
  always_comb begin
    o_req_ready = (state_q == ST_IDLE);
    o_wb_cyc    = active;
    o_wb_stb    = (state_q == ST_REQ);
    o_wb_we     = we_q;
    o_wb_adr    = adr_q;
    o_wb_dat    = dat_q;
    o_wb_sel    = sel_q;
    o_rsp_valid = rsp_valid_q;
    o_rsp_rdata = rsp_rdata_q;
    o_rsp_err   = rsp_err_q;
  end

  // Bus fields load on accept, stay frozen during the cycle and clear on completion.
  always_comb begin
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    if (accept) begin
      we_d  = i_req_we;
      adr_d = i_req_addr;
      dat_d = i_req_we ? i_req_wdata : '0;
      sel_d = i_req_sel;
    end else if (done) begin
      we_d  = 1'b0;
      adr_d = '0;
      dat_d = '0;
      sel_d = '0;
    end
  end

  // Response for the cycle after completion; read data only on a clean read ack.
  always_comb begin
    rsp_valid_d = done;
    rsp_err_d   = done && done_err;
    rsp_rdata_d = '0;
    if (done && i_wb_ack && !done_err && !we_q) begin
      rsp_rdata_d = i_wb_dat;
    end
  end

  // Bus and response registers; all cleared by reset so an aborted cycle leaves no trace.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_leiwand_wb_master.sv
// Bench for leiwand_wb_master: instance 0 is pipelined with an 8-cycle
// timeout, instance 1 is classic with the timeout disabled. Expected
// responses are queued by the stimulus and consumed by a response monitor.
module tb_leiwand_wb_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_sel    [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];
  logic        wb_cyc     [2];
  logic        wb_stb     [2];
  logic        wb_we      [2];
  logic [31:0] wb_adr     [2];
  logic [31:0] wb_dat_o   [2];
  logic [3:0]  wb_sel     [2];
  logic [31:0] wb_dat_i   [2];
  logic        wb_ack     [2];
  logic        wb_err     [2];
  logic        wb_stall   [2];

  leiwand_wb_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PIPELINED(1), .TIMEOUT_CYCLES(8)
  ) dut_p (
    .i_clk(clk), .i_rst(rst[0]),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_we(req_we[0]),
    .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]), .i_req_sel(req_sel[0]),
    .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]),
    .o_wb_cyc(wb_cyc[0]), .o_wb_stb(wb_stb[0]), .o_wb_we(wb_we[0]),
    .o_wb_adr(wb_adr[0]), .o_wb_dat(wb_dat_o[0]), .o_wb_sel(wb_sel[0]),
    .i_wb_dat(wb_dat_i[0]), .i_wb_ack(wb_ack[0]), .i_wb_err(wb_err[0]), .i_wb_stall(wb_stall[0])
  );

  leiwand_wb_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PIPELINED(0), .TIMEOUT_CYCLES(0)
  ) dut_c (
    .i_clk(clk), .i_rst(rst[1]),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_we(req_we[1]),
    .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]), .i_req_sel(req_sel[1]),
    .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]),
    .o_wb_cyc(wb_cyc[1]), .o_wb_stb(wb_stb[1]), .o_wb_we(wb_we[1]),
    .o_wb_adr(wb_adr[1]), .o_wb_dat(wb_dat_o[1]), .o_wb_sel(wb_sel[1]),
    .i_wb_dat(wb_dat_i[1]), .i_wb_ack(wb_ack[1]), .i_wb_err(wb_err[1]), .i_wb_stall(wb_stall[1])
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic push(input int k, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Response monitor: every rsp_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid[0] === 1'b1) begin
      if (q0.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL rsp0_unexpected: got rsp_valid=1, required no response");
      end else begin
        e = q0.pop_front();
        chk("rsp0_rdata", rsp_rdata[0], e.rdata);
        chkb("rsp0_err", rsp_err[0], e.err);
      end
    end
    if (rsp_valid[1] === 1'b1) begin
      if (q1.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL rsp1_unexpected: got rsp_valid=1, required no response");
      end else begin
        e = q1.pop_front();
        chk("rsp1_rdata", rsp_rdata[1], e.rdata);
        chkb("rsp1_err", rsp_err[1], e.err);
      end
    end
  end

  // Present one request at a negedge; returns at the first negedge with cyc/stb up.
  // Afterwards the request fields are scrambled to show they are not re-sampled.
  task automatic issue(input int k, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    chkb("issue_ready", req_ready[k], 1'b1);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_sel[k]   = s;
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_we[k]    = ~we;
    req_addr[k]  = a ^ 32'hBAD0_0000;
    req_wdata[k] = ~d;
    req_sel[k]   = ~s;
  endtask

  task automatic chk_bus(input int k, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    chkb("bus_cyc", wb_cyc[k], 1'b1);
    chkb("bus_stb", wb_stb[k], 1'b1);
    chkb("bus_we",  wb_we[k],  we);
    chk("bus_adr",  wb_adr[k], a);
    chk("bus_dat",  wb_dat_o[k], we ? d : 32'h0);
    chk("bus_sel",  32'(wb_sel[k]), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_sel[k] = '0; wb_dat_i[k] = '0; wb_ack[k] = 1'b0;
      wb_err[k] = 1'b0; wb_stall[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Reset state of both instances
    for (int k = 0; k < 2; k++) begin
      chkb("rst_ready", req_ready[k], 1'b1);
      chkb("rst_cyc", wb_cyc[k], 1'b0);
      chkb("rst_stb", wb_stb[k], 1'b0);
      chk("rst_adr", wb_adr[k], 32'h0);
      chkb("rst_rsp_valid", rsp_valid[k], 1'b0);
    end

    // 1: pipelined read, no stall, ack one cycle after the strobe
    issue(0, 1'b0, 32'h2000_0004, 32'h1111_1111, 4'hF);
    chk_bus(0, 1'b0, 32'h2000_0004, 32'h0, 4'hF);
    chkb("t1_ready_busy", req_ready[0], 1'b0);
    push(0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    chkb("t1_stb_one_cycle", wb_stb[0], 1'b0);
    chkb("t1_cyc_wait", wb_cyc[0], 1'b1);
    wb_ack[0] = 1'b1; wb_dat_i[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    wb_ack[0] = 1'b0;
    chkb("t1_rsp_valid", rsp_valid[0], 1'b1);
    chkb("t1_cyc_drop", wb_cyc[0], 1'b0);
    chkb("t1_ready_back", req_ready[0], 1'b1);

    // 2: pipelined write stalled three cycles, fields stable while stb is high
    issue(0, 1'b1, 32'h2000_0000, 32'h0000_0042, 4'h3);
    push(0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_bus(0, 1'b1, 32'h2000_0000, 32'h0000_0042, 4'h3);
      wb_stall[0] = (i < 3);
      @(negedge clk);
    end
    wb_stall[0] = 1'b0;
    chkb("t2_stb_drop", wb_stb[0], 1'b0);
    chkb("t2_cyc_wait", wb_cyc[0], 1'b1);
    wb_ack[0] = 1'b1; wb_dat_i[0] = 32'hFFFF_0000;
    @(negedge clk);
    wb_ack[0] = 1'b0;
    chk("t2_adr_cleared", wb_adr[0], 32'h0);
    chkb("t2_we_cleared", wb_we[0], 1'b0);

    // 3: classic read, stall toggling and ignored, ack in the fifth strobe cycle
    issue(1, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
    push(1, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chkb("t3_cyc", wb_cyc[1], 1'b1);
      chkb("t3_stb", wb_stb[1], 1'b1);
      chk("t3_adr", wb_adr[1], 32'h3000_0010);
      wb_stall[1] = (i % 2 == 0);
      if (i == 4) begin
        wb_ack[1] = 1'b1; wb_dat_i[1] = 32'h1234_5678;
      end
      @(negedge clk);
    end
    wb_ack[1] = 1'b0; wb_stall[1] = 1'b0;
    chkb("t3_cyc_drop", wb_cyc[1], 1'b0);
    chkb("t3_stb_drop", wb_stb[1], 1'b0);

    // 4: ack+err together -> error wins; then fastest ack; then stray acks in IDLE
    issue(0, 1'b0, 32'h2000_0008, 32'h0, 4'hF);
    push(0, 32'h0, 1'b1);
    wb_ack[0] = 1'b1; wb_err[0] = 1'b1; wb_dat_i[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    wb_ack[0] = 1'b0; wb_err[0] = 1'b0;
    chkb("t4_err_ready", req_ready[0], 1'b1);
    issue(0, 1'b0, 32'h2000_000C, 32'h0, 4'h5);
    push(0, 32'hA5A5_5A5A, 1'b0);
    wb_ack[0] = 1'b1; wb_dat_i[0] = 32'hA5A5_5A5A;
    @(negedge clk);
    chkb("t4_latency_rsp", rsp_valid[0], 1'b1);
    wb_ack[0] = 1'b1; wb_err[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_err[0] = (i == 1);
      @(negedge clk);
      chkb("t4_stray_cyc", wb_cyc[0], 1'b0);
      chkb("t4_stray_ready", req_ready[0], 1'b1);
    end
    wb_ack[0] = 1'b0; wb_err[0] = 1'b0;

    // 5a: silent slave, timeout of 8 -> cyc high exactly 8 cycles, error response
    wb_dat_i[0] = 32'hCAFE_F00D;
    issue(0, 1'b0, 32'h2000_0010, 32'h0, 4'hF);
    push(0, 32'h0, 1'b1);
    n = 0;
    for (int i = 0; i < 40 && wb_cyc[0] === 1'b1; i++) begin
      n++;
      @(negedge clk);
    end
    chk("t5_timeout_cycles", 32'(n), 32'd8);

    // 5b: timeout disabled -> cycle survives 1000 cycles, then completes on ack
    issue(1, 1'b1, 32'h3000_0000, 32'h55AA_55AA, 4'hF);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (wb_cyc[1] === 1'b1) n++;
      @(negedge clk);
    end
    chk("t5_no_timeout_cycles", 32'(n), 32'd1000);
    push(1, 32'h0, 1'b0);
    wb_ack[1] = 1'b1;
    @(negedge clk);
    wb_ack[1] = 1'b0;

    // 6: reset while waiting aborts silently
    issue(0, 1'b0, 32'h2000_0020, 32'h0, 4'hF);
    @(negedge clk);
    chkb("t6_in_wait", wb_stb[0], 1'b0);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chkb("t6_cyc", wb_cyc[0], 1'b0);
    chkb("t6_stb", wb_stb[0], 1'b0);
    chkb("t6_we", wb_we[0], 1'b0);
    chk("t6_adr", wb_adr[0], 32'h0);
    chk("t6_dat", wb_dat_o[0], 32'h0);
    chk("t6_sel", 32'(wb_sel[0]), 32'h0);
    chkb("t6_rsp_valid", rsp_valid[0], 1'b0);
    chkb("t6_ready", req_ready[0], 1'b1);

    // 6b: 128 back-to-back writes, each accepted in the previous response cycle
    for (int i = 0; i < 128; i++) begin
      issue(0, 1'b1, 32'h1000_0000 + 32'(i * 4), 32'(i) * 32'h0101_0101, 4'hF);
      push(0, 32'h0, 1'b0);
      chk("t6_b2b_adr", wb_adr[0], 32'h1000_0000 + 32'(i * 4));
      chk("t6_b2b_dat", wb_dat_o[0], 32'(i) * 32'h0101_0101);
      wb_ack[0] = 1'b1;
      @(negedge clk);
      wb_ack[0] = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
